// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared constants for the APB requester arbiter:
//   - FSM state encodings (IDLE / BUSY / DONE)
//   - default parameter values for the arbiter and its interface
//   - ptr_width(): width of a requester index (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package apb_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDRESS_WIDTH  = 32;
    localparam int DEF_STRB_WIDTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_arbiter_if
// Bundles every signal of the arbiter except clock and reset.
//   Requester side : REQ_VALID/ADDR/DATA/WRITE/STRB in, REQ_GNT out,
//                    RSP_VALID/RSP_RDATA/RSP_ERR out
//   Master side    : IN_ADDR/DATA/WRITE/STRB + Transfer out,
//                    PENABLE/PREADY/PSLVERR/OUT_RDATA in
// Modports:
//   master - taken by the arbiter (it acts as the command source of the
//            shared APB master)
//   slave  - taken by the surrounding logic (requesters + APB master)
// ---------------------------------------------------------------------------
interface apb_arbiter_if import apb_arb_pkg::*; #(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int STRB_WIDTH    = DEF_STRB_WIDTH
) ();

    logic [NUM_REQ-1:0]               REQ_VALID;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_DATA;
    logic [NUM_REQ-1:0]               REQ_WRITE;
    logic [NUM_REQ*STRB_WIDTH-1:0]    REQ_STRB;
    logic [NUM_REQ-1:0]               REQ_GNT;
    logic [NUM_REQ-1:0]               RSP_VALID;
    logic [DATA_WIDTH-1:0]            RSP_RDATA;
    logic                             RSP_ERR;
    logic [ADDRESS_WIDTH-1:0]         IN_ADDR;
    logic [DATA_WIDTH-1:0]            IN_DATA;
    logic                             IN_WRITE;
    logic [STRB_WIDTH-1:0]            IN_STRB;
    logic                             Transfer;
    logic                             PENABLE;
    logic                             PREADY;
    logic                             PSLVERR;
    logic [DATA_WIDTH-1:0]            OUT_RDATA;

    modport master (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, REQ_WRITE, REQ_STRB,
        input  PENABLE, PREADY, PSLVERR, OUT_RDATA,
        output REQ_GNT, RSP_VALID, RSP_RDATA, RSP_ERR,
        output IN_ADDR, IN_DATA, IN_WRITE, IN_STRB, Transfer
    );

    modport slave (
        output REQ_VALID, REQ_ADDR, REQ_DATA, REQ_WRITE, REQ_STRB,
        output PENABLE, PREADY, PSLVERR, OUT_RDATA,
        input  REQ_GNT, RSP_VALID, RSP_RDATA, RSP_ERR,
        input  IN_ADDR, IN_DATA, IN_WRITE, IN_STRB, Transfer
    );

endinterface

// File: rtl/apb_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector.
//   req   [NUM_REQ] : request vector
//   ptr   [PW]      : index where the search starts (highest priority)
//   gnt   [NUM_REQ] : one-hot winner (all zero when nothing requests)
//   valid           : at least one request present
// ---------------------------------------------------------------------------
module rr_picker import apb_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PW      = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    localparam int PW1 = PW + 1;

    // pos = (ptr + off) mod NUM_REQ; one extra bit holds the unwrapped sum
    logic [PW:0] pos;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = {1'b0, ptr} + PW1'(off);
            if (pos >= PW1'(NUM_REQ)) begin
                pos = pos - PW1'(NUM_REQ);
            end
            if (!valid && req[pos[PW-1:0]]) begin
                gnt[pos[PW-1:0]] = 1'b1;
                valid            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
// Shares one APB master between NUM_REQ requesters. A round-robin winner is
// picked in IDLE, its command is latched onto IN_* and Transfer is raised
// until the master reports PENABLE&PREADY; the response is then returned to
// the owning requester as a one-cycle RSP_VALID pulse.
// Ports:
//   PCLK   - clock
//   PRESET - asynchronous, active-high reset
//   bus    - apb_arbiter_if.master (requester and APB master signals)
// Build option:
//   APB_ARB_TIMEOUT_EN - adds a BUSY watchdog of TIMEOUT_CYCLES cycles that
//                        completes the transfer with RSP_ERR=1.
// ---------------------------------------------------------------------------
module apb_arbiter import apb_arb_pkg::*; #(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int STRB_WIDTH     = DEF_STRB_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_arbiter_if.master bus
);

    localparam int              PW       = ptr_width(NUM_REQ);
    localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_REQ - 1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]               state_reg, state_next;
    logic [PW-1:0]            ptr_reg, owner_reg, win_idx;
    logic                     err_reg;
    logic [NUM_REQ-1:0]       gnt_reg, rsp_valid_reg, pick_gnt;
    logic                     pick_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata_reg;
    logic                     rsp_err_reg;
    logic [ADDRESS_WIDTH-1:0] in_addr_reg;
    logic [DATA_WIDTH-1:0]    in_data_reg;
    logic                     in_write_reg;
    logic [STRB_WIDTH-1:0]    in_strb_reg;
    logic                     apb_done;
    logic                     to_hit;

    // Per-requester views of the flattened command buses
    logic [ADDRESS_WIDTH-1:0] req_addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]    req_data_arr [NUM_REQ];
    logic [STRB_WIDTH-1:0]    req_strb_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign req_addr_arr[gi] = bus.REQ_ADDR[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign req_data_arr[gi] = bus.REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
        assign req_strb_arr[gi] = bus.REQ_STRB[gi*STRB_WIDTH +: STRB_WIDTH];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .req   (bus.REQ_VALID),
        .ptr   (ptr_reg),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign apb_done = bus.PENABLE & bus.PREADY;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_reg;

    // Counter is zero on the first BUSY cycle, so the hit lands on the
    // TIMEOUT_CYCLES-th BUSY cycle.
    assign to_hit = (state_reg == ST_BUSY) && (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            to_cnt_reg <= '0;
        end else if (state_reg != ST_BUSY) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Completion takes precedence over a watchdog hit in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (pick_valid) state_next = ST_BUSY;
            ST_BUSY: if (apb_done || to_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            err_reg       <= 1'b0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            in_addr_reg   <= '0;
            in_data_reg   <= '0;
            in_write_reg  <= 1'b0;
            in_strb_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_reg      <= pick_gnt;
                        owner_reg    <= win_idx;
                        ptr_reg      <= (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
                        err_reg      <= 1'b0;
                        in_addr_reg  <= req_addr_arr[win_idx];
                        in_data_reg  <= req_data_arr[win_idx];
                        in_write_reg <= bus.REQ_WRITE[win_idx];
                        in_strb_reg  <= req_strb_arr[win_idx];
                    end
                end
                ST_BUSY: begin
                    if (apb_done) begin
                        err_reg <= bus.PSLVERR;
                    end else if (to_hit) begin
                        err_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Response is registered here so it appears in the cycle
                    // after DONE, together with the master back in IDLE.
                    rsp_valid_reg[owner_reg] <= 1'b1;
                    rsp_rdata_reg            <= bus.OUT_RDATA;
                    rsp_err_reg              <= err_reg;
                end
                default: ;
            endcase
        end
    end

    assign bus.REQ_GNT   = gnt_reg;
    assign bus.RSP_VALID = rsp_valid_reg;
    assign bus.RSP_RDATA = rsp_rdata_reg;
    assign bus.RSP_ERR   = rsp_err_reg;
    assign bus.IN_ADDR   = in_addr_reg;
    assign bus.IN_DATA   = in_data_reg;
    assign bus.IN_WRITE  = in_write_reg;
    assign bus.IN_STRB   = in_strb_reg;
    assign bus.Transfer  = (state_reg == ST_BUSY) & ~apb_done & ~to_hit;

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
// Directed + randomized bench for apb_arbiter. Emulates the APB master
// (SETUP then ACCESS with programmable wait states) and the requesters, and
// predicts grants from a simple round-robin pointer model.
// ---------------------------------------------------------------------------
module tb_apb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    apb_arbiter_if #(
        .NUM_REQ       (N),
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .STRB_WIDTH    (SW)
    ) bus_if ();

    apb_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .STRB_WIDTH     (SW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus_if.master)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp  = 0;
    int n_err  = 0;
    int rr_ptr = 0;

    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_data  [N];
    logic          m_write [N];
    logic [SW-1:0] m_strb  [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic rand_cmds();
        for (int i = 0; i < N; i++) begin
            m_addr[i]  = $urandom;
            m_data[i]  = $urandom;
            m_write[i] = 1'($urandom_range(0, 1));
            m_strb[i]  = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic drive_reqs(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            bus_if.REQ_ADDR[i*AW +: AW] = m_addr[i];
            bus_if.REQ_DATA[i*DW +: DW] = m_data[i];
            bus_if.REQ_WRITE[i]         = m_write[i];
            bus_if.REQ_STRB[i*SW +: SW] = m_strb[i];
        end
        bus_if.REQ_VALID = mask;
    endtask

    // Round-robin reference: first requester at or after the pointer.
    function automatic int model_pick(input logic [N-1:0] mask);
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (rr_ptr + off) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},   bus_if.REQ_GNT, 0);
        chk({tag, "_rspv"},  bus_if.RSP_VALID, 0);
        chk({tag, "_rspd"},  bus_if.RSP_RDATA, 0);
        chk({tag, "_rspe"},  bus_if.RSP_ERR, 0);
        chk({tag, "_addr"},  bus_if.IN_ADDR, 0);
        chk({tag, "_data"},  bus_if.IN_DATA, 0);
        chk({tag, "_wr"},    bus_if.IN_WRITE, 0);
        chk({tag, "_strb"},  bus_if.IN_STRB, 0);
        chk({tag, "_xfer"},  bus_if.Transfer, 0);
    endtask

    // One complete transaction, starting in an IDLE cycle with the requests
    // already driven. Ends in the cycle where RSP_VALID is expected.
    task automatic run_txn(input int w, input int waits, input logic slverr,
                           input logic [DW-1:0] prdata, input bit scramble);
        logic [N-1:0]  e_oh;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_write;
        logic [SW-1:0] e_strb;
        e_oh    = '0;
        e_oh[w] = 1'b1;
        e_addr  = m_addr[w];
        e_data  = m_data[w];
        e_write = m_write[w];
        e_strb  = m_strb[w];

        tick();                                       // grant edge
        chk("grant",       bus_if.REQ_GNT, e_oh);
        chk("grant_rspv",  bus_if.RSP_VALID, 0);
        chk("grant_xfer",  bus_if.Transfer, 1);
        chk("in_addr",     bus_if.IN_ADDR, e_addr);
        chk("in_data",     bus_if.IN_DATA, e_data);
        chk("in_write",    bus_if.IN_WRITE, e_write);
        chk("in_strb",     bus_if.IN_STRB, e_strb);
        rr_ptr = (w + 1) % N;

        if (scramble) begin
            bus_if.REQ_VALID = 4'($urandom);
            bus_if.REQ_ADDR  = {$urandom, $urandom, $urandom, $urandom};
            bus_if.REQ_DATA  = {$urandom, $urandom, $urandom, $urandom};
            bus_if.REQ_WRITE = 4'($urandom);
            bus_if.REQ_STRB  = 16'($urandom);
        end else begin
            bus_if.REQ_VALID[w] = 1'b0;
        end

        tick();                                       // master SETUP
        chk("setup_xfer",  bus_if.Transfer, 1);
        chk("setup_gnt",   bus_if.REQ_GNT, 0);

        tick();                                       // first ACCESS cycle
        for (int a = 0; a <= waits; a++) begin
            if (a > 0) tick();
            bus_if.PENABLE = 1'b1;
            bus_if.PREADY  = (a == waits);
            bus_if.PSLVERR = (a == waits) ? slverr : 1'b0;
            if (a == waits) bus_if.OUT_RDATA = prdata;
            #1;
            chk("access_xfer", bus_if.Transfer, (a == waits) ? 1'b0 : 1'b1);
            chk("access_gnt",  bus_if.REQ_GNT, 0);
        end

        tick();                                       // DONE
        bus_if.PENABLE = 1'b0;
        bus_if.PREADY  = 1'b0;
        bus_if.PSLVERR = 1'b0;
        chk("done_rspv",   bus_if.RSP_VALID, 0);
        chk("done_xfer",   bus_if.Transfer, 0);

        tick();                                       // response cycle
        chk("rsp_valid",   bus_if.RSP_VALID, e_oh);
        chk("rsp_rdata",   bus_if.RSP_RDATA, prdata);
        chk("rsp_err",     bus_if.RSP_ERR, slverr);
        chk("rsp_gnt",     bus_if.REQ_GNT, 0);
        chk("hold_addr",   bus_if.IN_ADDR, e_addr);
        chk("hold_data",   bus_if.IN_DATA, e_data);
        $display("txn req=%0d waits=%0d err=%0b rdata=0x%08h", w, waits, slverr, prdata);
    endtask

    initial begin
        logic [N-1:0] mask;
        int w;

        bus_if.REQ_VALID = '0;
        bus_if.REQ_ADDR  = '0;
        bus_if.REQ_DATA  = '0;
        bus_if.REQ_WRITE = '0;
        bus_if.REQ_STRB  = '0;
        bus_if.PENABLE   = 1'b0;
        bus_if.PREADY    = 1'b0;
        bus_if.PSLVERR   = 1'b0;
        bus_if.OUT_RDATA = '0;

        // Reset with every requester already asserting
        rand_cmds();
        drive_reqs(4'hF);
        tick();
        tick();
        check_all_zero("reset");
        PRESET = 1'b0;

        // All four held: grants 0,1,2,3, each response before the next grant
        for (int g = 0; g < N; g++) begin
            run_txn(g, $urandom_range(0, 2), 1'b0, $urandom, 1'b0);
        end

        // Write from req0, zero wait states
        m_addr[0]  = 32'h0400_0010;
        m_data[0]  = 32'hDEAD_BEEF;
        m_write[0] = 1'b1;
        m_strb[0]  = 4'hF;
        drive_reqs(4'b0001);
        run_txn(0, 0, 1'b0, 32'h0, 1'b0);

        // Read from req2, three wait states
        m_write[2] = 1'b0;
        drive_reqs(4'b0100);
        run_txn(2, 3, 1'b0, 32'h1234_5678, 1'b0);

        // Slave error on a req1 write, then everyone asks: req2 wins
        m_write[1] = 1'b1;
        drive_reqs(4'b0010);
        run_txn(1, 0, 1'b1, $urandom, 1'b0);
        rand_cmds();
        drive_reqs(4'hF);
        run_txn(2, 1, 1'b0, $urandom, 1'b0);
        bus_if.REQ_VALID = '0;

        // Randomized traffic against the round-robin model
        for (int it = 0; it < 30; it++) begin
            rand_cmds();
            mask = 4'($urandom_range(1, 15));
            drive_reqs(mask);
            w = model_pick(mask);
            run_txn(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, 1'b1);
        end
        bus_if.REQ_VALID = '0;

        tick();
        chk("idle_gnt",  bus_if.REQ_GNT, 0);
        chk("idle_xfer", bus_if.Transfer, 0);

        // Stalled transfer: PREADY never rises
        rand_cmds();
        mask = 4'($urandom_range(1, 15));
        drive_reqs(mask);
        w = model_pick(mask);
        tick();
        mask    = '0;
        mask[w] = 1'b1;
        chk("stall_grant", bus_if.REQ_GNT, mask);
        rr_ptr = (w + 1) % N;
        bus_if.REQ_VALID = '0;
        tick();
        tick();
        bus_if.PENABLE = 1'b1;
        bus_if.PREADY  = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        for (int k = 2; k <= 15; k++) begin
            chk("to_xfer", bus_if.Transfer, (k < 15) ? 1'b1 : 1'b0);
            chk("to_rspv", bus_if.RSP_VALID, 0);
            tick();
        end
        chk("to_done_rspv", bus_if.RSP_VALID, 0);
        tick();
        chk("to_rsp_valid", bus_if.RSP_VALID, mask);
        chk("to_rsp_err",   bus_if.RSP_ERR, 1);
        $display("timeout req=%0d err=%0b", w, bus_if.RSP_ERR);
        bus_if.PENABLE = 1'b0;
        rand_cmds();
        drive_reqs(4'hF);
        w = model_pick(4'hF);
        tick();
        mask    = '0;
        mask[w] = 1'b1;
        chk("stall2_grant", bus_if.REQ_GNT, mask);
        bus_if.REQ_VALID = '0;
        tick();
        tick();
`else
        for (int k = 0; k < 100; k++) begin
            chk("stall_xfer", bus_if.Transfer, 1);
            chk("stall_rspv", bus_if.RSP_VALID, 0);
            tick();
        end
        $display("stall req=%0d xfer=%0b after 100 cycles", w, bus_if.Transfer);
`endif

        // Reset in the middle of BUSY
        PRESET = 1'b1;
        #1;
        check_all_zero("rst_busy");
        tick();
        check_all_zero("rst_next");
        bus_if.PENABLE = 1'b0;
        bus_if.PREADY  = 1'b0;
        rand_cmds();
        drive_reqs(4'hF);
        tick();
        chk("rst_hold_rspv", bus_if.RSP_VALID, 0);
        PRESET = 1'b0;
        rr_ptr = 0;
        run_txn(0, 0, 1'b0, $urandom, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the APB master.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: write/read data width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32: address width.
REQ-004 SHALL have parameter STRB_WIDTH, default 4: write strobe width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16: BUSY-state watchdog limit, used only with APB_ARB_TIMEOUT_EN.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 SHALL have port PCLK  in  1  clock.
REQ-008 SHALL have port PRESET  in  1  reset.
REQ-009 SHALL have port REQ_VALID  in  NUM_REQ  per-requester request, held until granted; may drop before grant.
REQ-010 SHALL have port REQ_ADDR  in  NUM_REQ*ADDRESS_WIDTH  flattened addresses, requester i at slice i.
REQ-011 SHALL have port REQ_DATA  in  NUM_REQ*DATA_WIDTH  flattened write data.
REQ-012 SHALL have port REQ_WRITE  in  NUM_REQ  1=write, 0=read.
REQ-013 SHALL have port REQ_STRB  in  NUM_REQ*STRB_WIDTH  flattened write strobes.
REQ-014 SHALL have port REQ_GNT  out  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-015 SHALL have port RSP_VALID  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
REQ-016 SHALL have port RSP_RDATA  out  DATA_WIDTH  read data, valid with RSP_VALID.
REQ-017 SHALL have port RSP_ERR  out  1  error flag, valid with RSP_VALID.
REQ-018 SHALL have ports IN_ADDR, IN_DATA, IN_WRITE, IN_STRB  out  master widths  latched command to the APB master.
REQ-019 SHALL have port Transfer  out  1  transfer request to the APB master.
REQ-020 SHALL have ports PENABLE, PREADY, PSLVERR  in  1 each, and OUT_RDATA  in  DATA_WIDTH, all observed from the master/bus.

Function
REQ-021 SHALL implement states IDLE, BUSY, DONE.
REQ-022 In IDLE with any REQ_VALID set, SHALL select a winner by round-robin, starting the search at pointer PTR.
REQ-023 On selection, SHALL pulse REQ_GNT[winner], register the winner's command into IN_*, record it as owner, set PTR=(winner+1) mod NUM_REQ, and enter BUSY.
REQ-024 Transfer SHALL equal (state==BUSY) AND NOT (PENABLE AND PREADY); this is the only combinational path from inputs.
REQ-025 In BUSY, on PENABLE&PREADY, SHALL latch PSLVERR into an error flag and enter DONE.
REQ-026 In DONE, SHALL assert RSP_VALID[owner] for exactly one cycle, with RSP_RDATA=OUT_RDATA and RSP_ERR=error flag, then return to IDLE.
REQ-027 IN_* SHALL hold stable from grant until the next grant; REQ_VALID changes during BUSY/DONE are ignored.
REQ-028 Grant-to-RSP_VALID latency SHALL be 4 cycles with zero wait states, plus one cycle per PREADY wait state.
REQ-029 A new grant SHALL be possible in the cycle after DONE; the master is guaranteed back in its IDLE state.

Reset
REQ-030 On PRESET, SHALL force: state=IDLE, PTR=0, owner=0, error flag=0, all outputs 0, and any in-flight request dropped with no RSP_VALID.

Configuration
REQ-031 With APB_ARB_TIMEOUT_EN defined, SHALL count BUSY cycles; on reaching TIMEOUT_CYCLES without completion, SHALL force Transfer low, set error flag=1, and enter DONE.
REQ-032 Without APB_ARB_TIMEOUT_EN, SHALL omit the counter; BUSY waits indefinitely.

Structure
REQ-033 SHALL place state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b11) and default width constants in shared package apb_arb_pkg.
REQ-034 SHALL implement winner selection in combinational sub-module rr_picker (inputs: request vector, PTR; outputs: one-hot winner, valid).

Verification
REQ-035 Write: req0, addr 0x0400_0010, data 0xDEADBEEF, strb 0xF, zero wait -> REQ_GNT[0]; IN_* match; RSP_VALID[0] 4 cycles later; RSP_ERR=0.
REQ-036 All four REQ_VALID held -> grants in order 0,1,2,3; each RSP_VALID precedes the next grant.
REQ-037 Read: req2, PRDATA=0x1234_5678, 3 wait states -> RSP_VALID[2] 7 cycles after grant; RSP_RDATA=0x12345678.
REQ-038 PSLVERR=1 with PREADY on a req1 write -> RSP_VALID[1] with RSP_ERR=1; next grant goes to req2.
REQ-039 PREADY held 0 -> with the macro defined, RSP_ERR=1 after 16 BUSY cycles; without it, Transfer stays 1 through 100 cycles.
REQ-040 PRESET pulsed during BUSY -> all outputs 0 next cycle, no RSP_VALID, first grant afterward goes to req0.
